// File: rtl/aes_key_schedule_if.sv
// Bundle between the key-load path, the key schedule and the iterative cipher core.
// The master drives start/key/abort and round-key ready; the slave returns status and round keys.
interface aes_key_schedule_if #(
  parameter int unsigned MAX_KEY_L = 256,
  parameter int unsigned DATA_W    = 128
);
  logic                 start;
  logic [1:0]           key_mode;
  logic [MAX_KEY_L-1:0] cipher_key;
  logic                 abort;
  logic                 busy;
  logic                 err;
  logic                 rk_valid;
  logic                 rk_ready;
  logic [DATA_W-1:0]    rk_data;
  logic [3:0]           rk_index;
  logic                 rk_last;

  modport master (
    output start, key_mode, cipher_key, abort, rk_ready,
    input  busy, err, rk_valid, rk_data, rk_index, rk_last
  );

  modport slave (
    input  start, key_mode, cipher_key, abort, rk_ready,
    output busy, err, rk_valid, rk_data, rk_index, rk_last
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle through a single
// SubWord unit, streaming round keys 0..Nr over a valid/ready handshake.
module aes_key_schedule #(
  parameter int unsigned MAX_KEY_L = 256,
  parameter int unsigned DATA_W    = 128
) (
  input logic               i_clk,
  input logic               i_rst_n,
  aes_key_schedule_if.slave io_bus
);
  localparam int unsigned NKMAX = MAX_KEY_L / 32;
  localparam int unsigned IdxW  = $clog2(NKMAX);

  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_key_schedule: DATA_W must be 128");
  end
  if (MAX_KEY_L != 128 && MAX_KEY_L != 192 && MAX_KEY_L != 256) begin : g_bad_key_l
    $error("aes_key_schedule: MAX_KEY_L must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {StIdle, StGen, StDoneWait} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254 = a^2 * a^4 * ... * a^128) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int n = 1; n < 8; n++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_e                 r_state, w_state_nxt;
  logic [NKMAX-1:0][31:0] r_win, w_win_nxt;
  logic [5:0]             r_i;
  logic [2:0]             r_pos;
  logic [7:0]             r_rcon;
  logic [1:0]             r_mode;
  logic [95:0]            r_part;
  logic                   r_err, r_rk_valid, r_rk_last;
  logic [127:0]           r_rk_data;
  logic [3:0]             r_rk_index;

  logic [3:0]      w_nk, w_nr;
  logic [IdxW-1:0] w_top;
  logic [31:0]     w_temp, w_sub_in, w_sub_out, w_f, w_word;
  logic            w_key_phase, w_rot_step, w_sub_step, w_mode_ok;
  logic            w_load, w_hs, w_stall, w_adv, w_last_word;
  logic            w_start_ok, w_start_bad, w_abort, w_busy, w_gen, w_idle;

  always_comb begin
    unique case (r_mode)
      2'd0:    begin w_nk = 4'd4; w_nr = 4'd10; end
      2'd1:    begin w_nk = 4'd6; w_nr = 4'd12; end
      default: begin w_nk = 4'd8; w_nr = 4'd14; end
    endcase
  end

  // Window is a shift register: [0] is w[i-Nk], [Nk-1] is w[i-1]. During the key phase the key
  // words rotate through it so the layout is already correct when expansion proper begins.
  assign w_top       = IdxW'(w_nk - 4'd1);
  assign w_temp      = r_win[w_top];
  assign w_key_phase = (r_i < {2'b00, w_nk});
  assign w_rot_step  = !w_key_phase && (r_pos == 3'd0);
  assign w_sub_step  = !w_key_phase && (w_nk == 4'd8) && (r_pos == 3'd4);
  assign w_sub_in    = w_rot_step ? {w_temp[23:0], w_temp[31:24]} : w_temp;
  assign w_sub_out   = sub_word(w_sub_in);
  assign w_f         = w_rot_step ? (w_sub_out ^ {r_rcon, 24'h0}) :
                       w_sub_step ? w_sub_out : w_temp;
  assign w_word      = w_key_phase ? r_win[0] : (r_win[0] ^ w_f);

  always_comb begin
    w_win_nxt        = r_win >> 32;
    w_win_nxt[w_top] = w_word;
  end

  assign w_mode_ok   = (io_bus.key_mode == 2'd0) ||
                       ((io_bus.key_mode == 2'd1) && (MAX_KEY_L >= 192)) ||
                       ((io_bus.key_mode == 2'd2) && (MAX_KEY_L >= 256));
  assign w_start_ok  = w_idle && io_bus.start && w_mode_ok;
  assign w_start_bad = w_idle && io_bus.start && !w_mode_ok;
  assign w_abort     = io_bus.abort && !w_idle;
  assign w_load      = (r_i[1:0] == 2'b11);
  assign w_hs        = r_rk_valid && io_bus.rk_ready;
  assign w_stall     = w_load && r_rk_valid && !io_bus.rk_ready;
  assign w_adv       = w_gen && !io_bus.abort && !w_stall;
  assign w_last_word = (r_i == {w_nr, 2'b11});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:     if (w_start_ok) w_state_nxt = StGen;
      StGen: begin
        if (w_abort)                   w_state_nxt = StIdle;
        else if (w_adv && w_last_word) w_state_nxt = StDoneWait;
      end
      StDoneWait: begin
        if (w_abort)                w_state_nxt = StIdle;
        else if (w_hs && r_rk_last) w_state_nxt = StIdle;
      end
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_idle = (r_state == StIdle);
    w_gen  = (r_state == StGen);
    w_busy = !w_idle;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win      <= '0;
      r_i        <= '0;
      r_pos      <= '0;
      r_rcon     <= 8'h01;
      r_mode     <= '0;
      r_part     <= '0;
      r_err      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      r_rk_last  <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_start_ok) begin
        for (int j = 0; j < NKMAX; j++) begin
          r_win[j] <= io_bus.cipher_key[MAX_KEY_L-1-32*j -: 32];
        end
        r_mode <= io_bus.key_mode;
        r_i    <= '0;
        r_pos  <= '0;
        r_rcon <= 8'h01;
      end else if (w_adv) begin
        r_win <= w_win_nxt;
        r_i   <= r_i + 6'd1;
        r_pos <= (r_pos == 3'(w_nk - 4'd1)) ? 3'd0 : r_pos + 3'd1;
        if (w_rot_step) r_rcon <= xtime(r_rcon);
        if (!w_load)    r_part <= {r_part[63:0], w_word};
      end
      // Abort wins over a handshake; a load in the same cycle as a handshake replaces the key.
      if (w_abort) begin
        r_rk_valid <= 1'b0;
      end else if (w_adv && w_load) begin
        r_rk_valid <= 1'b1;
        r_rk_data  <= {r_part, w_word};
        r_rk_index <= r_i[5:2];
        r_rk_last  <= w_last_word;
      end else if (w_hs) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  assign io_bus.busy     = w_busy;
  assign io_bus.err      = r_err;
  assign io_bus.rk_valid = r_rk_valid;
  assign io_bus.rk_data  = r_rk_data;
  assign io_bus.rk_index = r_rk_index;
  assign io_bus.rk_last  = r_rk_last;
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, parametrised AES key-expansion engine with a runtime-selectable key length of 128, 192 or 256 bits. It generates one 32-bit schedule word per clock using a single shared SubWord unit and an on-the-fly Rcon register. It streams the Nr+1 round keys, round 0 first, over a valid/ready interface. It sits between the key-load path and an iterative (non-unrolled) cipher core, trading the fully pipelined per-round expansion for low area plus AES-192/256 support.

## Interface
- MAX_KEY_L, 256: widest supported key; legal values 128, 192, 256. Key modes wider than MAX_KEY_L are illegal.
- DATA_W, 128: round-key width; fixed at 128, any other value is a configuration error.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin expansion; sampled only in IDLE
- key_mode  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
- cipher_key  in  MAX_KEY_L  key, left-aligned: the key MSB is at bit MAX_KEY_L-1, unused LSBs are ignored; sampled with start
- abort  in  1  synchronous cancel of a running expansion
- busy  out  1  high from the cycle after start is accepted until the last round key is accepted
- err  out  1  one-cycle pulse: start seen with an illegal key_mode
- rk_valid  out  1  rk_data holds a round key
- rk_ready  in  1  consumer accepts rk_data when rk_valid && rk_ready
- rk_data  out  DATA_W  round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}, w[4k] in the MSBs
- rk_index  out  4  round number k, 0..Nr
- rk_last  out  1  high with rk_valid when k = Nr

## Operation
- Nk/Nr values: mode 0 is Nk=4, Nr=10 (44 words); mode 1 is Nk=6, Nr=12 (52 words); mode 2 is Nk=8, Nr=14 (60 words).
- FSM has three states: IDLE, GEN, DONE_WAIT.
- IDLE:
  - start with a legal mode: capture the key words into the window register (MAX_KEY_L/32 words), set word counter i=0, set rcon=0x01, go to GEN.
  - start with an illegal mode: pulse err and stay in IDLE.
- GEN produces one word per non-stalled cycle:
  - i < Nk: w[i] is key word i.
  - Otherwise temp = w[i-1], then w[i] = w[i-Nk] ^ f(temp), where f is:
    - i mod Nk = 0: SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon). xtime is a left shift, XORed with 0x1b if bit 7 was set.
    - Nk=8 and i mod 8 = 4: SubWord(temp).
    - Otherwise: temp unchanged.
  - The window holds only the last Nk words. Old words are not stored.
- Output assembly:
  - Words 4k..4k+2 go into a 3-word partial register.
  - On word 4k+3, the full round key loads straight into rk_data, rk_valid is set, and rk_index=k.
  - If the 4th word is due while rk_valid && !rk_ready, generation stalls: i, window and rcon hold.
  - A handshake in the same cycle as the load is legal; the new key replaces the old one with no bubble.
- GEN goes to DONE_WAIT after word 4Nr+3 is loaded. DONE_WAIT goes to IDLE when the rk_last beat is accepted. busy drops on that edge.
- abort in GEN or DONE_WAIT: the next edge clears rk_valid and returns to IDLE. abort overrides a simultaneous handshake. abort in IDLE has no effect.
- start while busy is ignored and does not raise err.
- rk_data, rk_index and rk_last stay stable while rk_valid && !rk_ready.

## Timing
- Reset values of outputs: busy=0, err=0, rk_valid=0, rk_data=0, rk_index=0, rk_last=0. Internal reset state: FSM=IDLE, rcon=0x01.
- Reset mid-operation clears all state immediately. No round key is emitted after reset release until a new start.
- Let E0 be the edge that accepts start.
  - Word j registers at edge E(j+1).
  - Round key k has rk_valid high from E(4k+4), given no stalls.
  - Last key is at E44 (AES-128), E52 (AES-192) or E60 (AES-256).
- With rk_ready held at 1, the stream delivers one round key every 4 cycles.
- err goes high on the edge after the illegal start and stays high for one cycle.
- Sustained throughput is one word per cycle. Each stalled cycle adds exactly one cycle of latency.

## Test plan
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 keys; k=1 is a0fafe1788542cb123a339392a6c7605; k=10 is d014f9a8c9ee2589e13f0cc8b6630ca6 at E44 with rk_last=1; busy low after the k=10 handshake.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> k=1 is 62f8ead2522c6b7bfe0c91f72402f5a5; k=12 is e98ba06f448c773c8ecc720401002202 with rk_last=1.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> k=14 is fe4890d1e6188d0b046df344706c631e at E60.
- Random rk_ready backpressure (about 50%) on all three modes -> identical key sequences; rk_data stable while stalled; no key lost or duplicated.
- start with key_mode=3, and mode 2 with MAX_KEY_L=128 -> err high for one cycle, busy stays 0; start during busy is ignored.
- abort at k=5, then a new start -> rk_valid=0 the next cycle and state is IDLE; the new run matches its reference vector. Async reset asserted mid-GEN -> all outputs return to their reset values immediately.
